// File: rtl/yarvi_lsu.sv
// Load/store initiator: queues execute-stage memory ops, issues them in order to the
// memory port, and turns tagged read responses into a registered register writeback.
module yarvi_lsu #(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int XW    = 64
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_address,
    input  logic [XW-1:0] req_writedata,
    input  logic [1:0]    req_sizelg2,
    input  logic [4:0]    req_rd,
    input  logic          req_signext,

    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_writeenable,
    output logic [AW-1:0] mem_address,
    output logic [XW-1:0] mem_writedata,
    output logic [1:0]    mem_sizelg2,
    output logic [4:0]    mem_readtag,
    output logic          mem_readsignextend,

    input  logic          mem_readdatavalid,
    input  logic [4:0]    mem_readdatatag,
    input  logic [XW-1:0] mem_readdata,

    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic [XW-1:0] wb_val,
    output logic [31:0]   pending,
    output logic          misaligned,
    output logic          resp_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [XW-1:0] data;
        logic [1:0]    size;
        logic [4:0]    rd;
        logic          signext;
    } op_t;

    op_t            fifo_q [DEPTH];
    op_t            head;
    op_t            new_op;

    logic [PW:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]    rd_ptr_q, rd_ptr_d;
    logic [31:0]    pending_q, pending_d;
    logic           misaligned_q, misaligned_d;
    logic           wb_valid_q, wb_valid_d;
    logic [4:0]     wb_rd_q, wb_rd_d;
    logic [XW-1:0]  wb_val_q, wb_val_d;
    logic           resp_err_q, resp_err_d;

    logic           full;
    logic           empty;
    logic           addr_misaligned;
    logic           accept;
    logic           push;
    logic           pop;
    logic           resp_hit;
    logic           resp_bad;

    always_comb begin
        addr_misaligned = 1'b0;
        case (req_sizelg2)
            2'd1:    addr_misaligned = req_address[0];
            2'd2:    addr_misaligned = |req_address[1:0];
            2'd3:    addr_misaligned = |req_address[2:0];
            default: addr_misaligned = 1'b0;
        endcase
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // A load to a register with a load already in flight waits for that response.
    assign req_ready = !full && !(!req_write && pending_q[req_rd]);
    assign accept    = req_valid && req_ready;
    assign push      = accept && !addr_misaligned;
    assign pop       = !empty && mem_ready;

    assign resp_hit  = mem_readdatavalid && pending_q[mem_readdatatag];
    assign resp_bad  = mem_readdatavalid && !pending_q[mem_readdatatag] &&
                       (mem_readdatatag != 5'd0);

    assign new_op = '{write:   req_write,
                      addr:    req_address,
                      data:    req_writedata,
                      size:    req_sizelg2,
                      rd:      req_rd,
                      signext: req_signext};

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pending_d    = pending_q;
        misaligned_d = accept && addr_misaligned;
        wb_valid_d   = resp_hit;
        wb_rd_d      = wb_rd_q;
        wb_val_d     = wb_val_q;
        resp_err_d   = resp_err_q | resp_bad;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Clear before set; the ready rule keeps the two indices distinct.
        if (resp_hit) begin
            pending_d[mem_readdatatag] = 1'b0;
            wb_rd_d                    = mem_readdatatag;
            wb_val_d                   = mem_readdata;
        end
        if (push && !req_write && (req_rd != 5'd0)) begin
            pending_d[req_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= '0;
            misaligned_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_val_q     <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pending_q    <= pending_d;
            misaligned_q <= misaligned_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_val_q     <= wb_val_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= new_op;
        end
    end

    assign head = fifo_q[rd_ptr_q[PW-1:0]];

    assign mem_valid          = !empty;
    assign mem_writeenable    = head.write;
    assign mem_address        = head.addr;
    assign mem_writedata      = head.data;
    assign mem_sizelg2        = head.size;
    assign mem_readtag        = head.rd;
    assign mem_readsignextend = head.signext;

    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_val     = wb_val_q;
    assign pending    = pending_q;
    assign misaligned = misaligned_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_yarvi_lsu.sv
// Scoreboard bench for yarvi_lsu: expected issues and writebacks are queued as stimulus
// is driven and compared by a negedge monitor; scenario tasks check control outputs inline.
module tb_yarvi_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signext;
    logic [63:0] req_address, req_writedata;
    logic [1:0]  req_sizelg2;
    logic [4:0]  req_rd;
    logic        mem_valid, mem_ready, mem_writeenable, mem_readsignextend;
    logic [63:0] mem_address, mem_writedata;
    logic [1:0]  mem_sizelg2;
    logic [4:0]  mem_readtag;
    logic        mem_readdatavalid;
    logic [4:0]  mem_readdatatag;
    logic [63:0] mem_readdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_val;
    logic [31:0] pending;
    logic        misaligned, resp_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic [1:0]  s;
        logic [4:0]  t;
        logic        x;
    } iss_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] val;
    } wb_t;

    iss_t        exp_iss[$];
    wb_t         exp_wb[$];
    logic [31:0] exp_pending = '0;

    yarvi_lsu #(.DEPTH(4), .AW(64), .XW(64)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_writedata(req_writedata),
        .req_sizelg2(req_sizelg2), .req_rd(req_rd), .req_signext(req_signext),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_writeenable(mem_writeenable), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_sizelg2(mem_sizelg2),
        .mem_readtag(mem_readtag), .mem_readsignextend(mem_readsignextend),
        .mem_readdatavalid(mem_readdatavalid), .mem_readdatatag(mem_readdatatag),
        .mem_readdata(mem_readdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_val(wb_val),
        .pending(pending), .misaligned(misaligned), .resp_err(resp_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin : monitor
        iss_t ge, ee;
        wb_t  gw, ew;
        if (!reset) begin
            if (mem_valid && mem_ready) begin
                checks++;
                ge = {mem_writeenable, mem_address, mem_writedata, mem_sizelg2,
                      mem_readtag, mem_readsignextend};
                if (exp_iss.size() == 0) begin
                    failures++;
                    $display("FAIL issue_unexpected got addr=%h expected no issue", mem_address);
                end else begin
                    ee = exp_iss.pop_front();
                    if (ge !== ee) begin
                        failures++;
                        $display("FAIL issue_order got=%h expected=%h", ge, ee);
                    end
                end
            end
            if (wb_valid) begin
                checks++;
                gw = {wb_rd, wb_val};
                if (exp_wb.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected got rd=%0d val=%h expected no writeback", wb_rd, wb_val);
                end else begin
                    ew = exp_wb.pop_front();
                    if (gw !== ew) begin
                        failures++;
                        $display("FAIL wb_data got=%h expected=%h", gw, ew);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic w, input logic [63:0] a, input logic [63:0] d,
                            input logic [1:0] s, input logic [4:0] rd, input logic x);
        req_valid     = 1'b1;
        req_write     = w;
        req_address   = a;
        req_writedata = d;
        req_sizelg2   = s;
        req_rd        = rd;
        req_signext   = x;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        #1;
    endtask

    task automatic drive_resp(input logic [4:0] t, input logic [63:0] d);
        mem_readdatavalid = 1'b1;
        mem_readdatatag   = t;
        mem_readdata      = d;
        if (t != 5'd0 && exp_pending[t]) begin
            exp_wb.push_back({t, d});
            exp_pending[t] = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b expected=1", req_ready); end
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b expected=0", mem_valid); end
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h expected=0", pending); end
        checks++; if ({wb_valid, misaligned, resp_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b expected=000", {wb_valid, misaligned, resp_err}); end
        checks++; if (mem_address !== 64'h0) begin failures++; $display("FAIL reset_mem_address got=%h expected=0", mem_address); end
    endtask

    task automatic test_load();
        mem_ready = 1'b1;
        drive_op(1'b0, 64'h1000, 64'h0, 2'd3, 5'd5, 1'b0);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL load_ready got=%b expected=1", req_ready); end
        exp_iss.push_back({1'b0, 64'h1000, 64'h0, 2'd3, 5'd5, 1'b0});
        exp_pending[5] = 1'b1;
        tick();
        idle();
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL load_latency got=%b expected=1", mem_valid); end
        checks++; if (mem_readtag !== 5'd5) begin failures++; $display("FAIL load_tag got=%0d expected=5", mem_readtag); end
        checks++; if (pending !== exp_pending) begin failures++; $display("FAIL load_pending_set got=%h expected=%h", pending, exp_pending); end
        tick();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL load_popped got=%b expected=0", mem_valid); end
        drive_resp(5'd5, 64'hDEAD);
        tick();
        mem_readdatavalid = 1'b0;
        checks++; if ({wb_valid, wb_rd, wb_val} !== {1'b1, 5'd5, 64'hDEAD}) begin failures++; $display("FAIL load_wb got=%b/%0d/%h expected=1/5/dead", wb_valid, wb_rd, wb_val); end
        checks++; if (pending !== exp_pending) begin failures++; $display("FAIL load_pending_clr got=%h expected=%h", pending, exp_pending); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL load_wb_pulse got=%b expected=0", wb_valid); end
    endtask

    task automatic test_full();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b1, 64'h2000 + 64'(8 * i), 64'hA0 + 64'(i), 2'd3, 5'(i + 1), 1'b0);
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL full_fill_ready i=%0d got=%b expected=1", i, req_ready); end
            exp_iss.push_back({1'b1, 64'h2000 + 64'(8 * i), 64'hA0 + 64'(i), 2'd3, 5'(i + 1), 1'b0});
            tick();
        end
        drive_op(1'b1, 64'h2040, 64'hB0, 2'd3, 5'd0, 1'b0);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b expected=0", req_ready); end
        tick();
        checks++; if ({mem_valid, mem_address, mem_writedata} !== {1'b1, 64'h2000, 64'hA0}) begin failures++; $display("FAIL full_stable got=%b/%h/%h expected=1/2000/a0", mem_valid, mem_address, mem_writedata); end
        mem_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_pop_no_push got=%b expected=0", req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop got=%b expected=1", req_ready); end
        exp_iss.push_back({1'b1, 64'h2040, 64'hB0, 2'd3, 5'd0, 1'b0});
        tick();
        idle();
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL full_push_pop got=%b expected=1", mem_valid); end
        tick(); tick(); tick();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b expected=0", mem_valid); end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        drive_op(1'b0, 64'h3000, 64'h0, 2'd3, 5'd7, 1'b1);
        exp_iss.push_back({1'b0, 64'h3000, 64'h0, 2'd3, 5'd7, 1'b1});
        exp_pending[7] = 1'b1;
        tick();
        drive_op(1'b0, 64'h3008, 64'h0, 2'd3, 5'd7, 1'b1);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL raw_block got=%b expected=0", req_ready); end
        req_rd = 5'd8; req_address = 64'h3010;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL raw_other_rd got=%b expected=1", req_ready); end
        exp_iss.push_back({1'b0, 64'h3010, 64'h0, 2'd3, 5'd8, 1'b1});
        exp_pending[8] = 1'b1;
        tick();
        drive_op(1'b0, 64'h3018, 64'h0, 2'd2, 5'd7, 1'b0);
        tick();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL raw_hold got=%b expected=0", req_ready); end
        drive_resp(5'd7, 64'h1111);
        tick();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL raw_release got=%b expected=1", req_ready); end
        exp_iss.push_back({1'b0, 64'h3018, 64'h0, 2'd2, 5'd7, 1'b0});
        drive_resp(5'd8, 64'h2222);
        exp_pending[7] = 1'b1;
        tick();
        idle();
        checks++; if (pending !== exp_pending) begin failures++; $display("FAIL same_cycle_set_clr got=%h expected=%h", pending, exp_pending); end
        checks++; if ({wb_valid, wb_rd} !== {1'b1, 5'd8}) begin failures++; $display("FAIL b2b_wb got=%b/%0d expected=1/8", wb_valid, wb_rd); end
        drive_resp(5'd7, 64'h3333);
        tick();
        mem_readdatavalid = 1'b0;
        checks++; if ({wb_valid, wb_rd, pending} !== {1'b1, 5'd7, 32'h0}) begin failures++; $display("FAIL b2b_last got=%b/%0d/%h expected=1/7/0", wb_valid, wb_rd, pending); end
        tick();
    endtask

    task automatic test_misaligned();
        mem_ready = 1'b0;
        drive_op(1'b1, 64'h4000, 64'h55, 2'd3, 5'd0, 1'b0);
        exp_iss.push_back({1'b1, 64'h4000, 64'h55, 2'd3, 5'd0, 1'b0});
        tick();
        drive_op(1'b1, 64'h1002, 64'h66, 2'd2, 5'd0, 1'b0);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mis_ready got=%b expected=1", req_ready); end
        tick();
        idle();
        checks++; if ({misaligned, mem_address} !== {1'b1, 64'h4000}) begin failures++; $display("FAIL mis_pulse got=%b/%h expected=1/4000", misaligned, mem_address); end
        tick();
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_once got=%b expected=0", misaligned); end
        drive_op(1'b0, 64'h4001, 64'h0, 2'd1, 5'd12, 1'b0);
        tick();
        idle();
        checks++; if ({misaligned, pending} !== {1'b1, 32'h0}) begin failures++; $display("FAIL mis_load got=%b/%h expected=1/0", misaligned, pending); end
        mem_ready = 1'b1;
        tick();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL mis_occupancy got=%b expected=0", mem_valid); end
    endtask

    task automatic test_resp_err();
        drive_resp(5'd0, 64'h1);
        tick();
        mem_readdatavalid = 1'b0;
        checks++; if ({resp_err, wb_valid} !== 2'b00) begin failures++; $display("FAIL tag0_drop got=%b expected=00", {resp_err, wb_valid}); end
        drive_op(1'b0, 64'h5000, 64'h0, 2'd3, 5'd0, 1'b0);
        exp_iss.push_back({1'b0, 64'h5000, 64'h0, 2'd3, 5'd0, 1'b0});
        tick();
        idle();
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL rd0_pending got=%h expected=0", pending); end
        tick();
        drive_resp(5'd0, 64'h77);
        tick();
        drive_resp(5'd9, 64'h99);
        tick();
        mem_readdatavalid = 1'b0;
        checks++; if ({resp_err, wb_valid} !== 2'b10) begin failures++; $display("FAIL bad_tag got=%b expected=10", {resp_err, wb_valid}); end
        tick(); tick();
        checks++; if (resp_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b expected=1", resp_err); end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        drive_op(1'b1, 64'h6000, 64'h1, 2'd3, 5'd0, 1'b0); tick();
        drive_op(1'b0, 64'h6008, 64'h0, 2'd3, 5'd3, 1'b0); tick();
        drive_op(1'b1, 64'h6010, 64'h2, 2'd3, 5'd0, 1'b0); tick();
        idle();
        checks++; if ({mem_valid, pending} !== {1'b1, 32'h8}) begin failures++; $display("FAIL mid_queued got=%b/%h expected=1/8", mem_valid, pending); end
        reset = 1'b1;
        #1;
        checks++; if ({mem_valid, pending, req_ready, resp_err} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin failures++; $display("FAIL mid_reset got=%b/%h/%b/%b expected=0/0/1/0", mem_valid, pending, req_ready, resp_err); end
        exp_pending = '0;
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        tick();
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL mid_discard got=%b expected=0", mem_valid); end
        drive_resp(5'd3, 64'h3);
        tick();
        mem_readdatavalid = 1'b0;
        checks++; if ({resp_err, wb_valid} !== 2'b10) begin failures++; $display("FAIL mid_stale_resp got=%b expected=10", {resp_err, wb_valid}); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_writedata = '0;
        req_sizelg2 = '0; req_rd = '0; req_signext = 1'b0;
        mem_ready = 1'b0; mem_readdatavalid = 1'b0; mem_readdatatag = '0; mem_readdata = '0;
        #12;
        test_reset();
        reset = 1'b0;
        tick();
        test_load();
        test_full();
        test_back_to_back();
        test_misaligned();
        test_resp_err();
        test_reset_mid();
        checks++; if (exp_iss.size() != 0) begin failures++; $display("FAIL issue_leftover got=%0d expected=0", exp_iss.size()); end
        checks++; if (exp_wb.size() != 0) begin failures++; $display("FAIL wb_leftover got=%0d expected=0", exp_wb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
